// File: rtl/frm_pkg.sv
// Shared definitions for the frame FCS checker and the upstream frame generator:
// CRC-8 polynomial, default payload limit and the checker FSM state type.
package frm_pkg;

  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam int         DEF_MAX_LEN = 1500;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } frm_state_e;

endpackage

// File: rtl/crc8_upd.sv
// Combinational CRC-8 byte update (MSB-first, no reflection): crc_out is the
// register value after shifting byte_in through a CRC seeded with crc_in.
module crc8_upd
  import frm_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] crc_v;

  always_comb begin
    crc_v = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) begin
      crc_v = crc_v[7] ? ({crc_v[6:0], 1'b0} ^ CRC8_POLY) : {crc_v[6:0], 1'b0};
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/frm_fcs_chk.sv
// Frame FCS checker: strips the trailing CRC-8 byte of each frame, checks it and
// emits the payload with an ok/err verdict. Define FRM_FCS_STAT_EN for good/bad counters.
module frm_fcs_chk
  import frm_pkg::*;
#(
  parameter int         MAX_LEN  = DEF_MAX_LEN,
  parameter logic [7:0] CRC_INIT = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic        din_vld,
  output logic [7:0]  dout,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_vld,
  output logic        frm_ok,
  output logic        frm_err,
  output logic [15:0] frm_len,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [16:0] LEN_LIM = 17'(MAX_LEN);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  frm_state_e  state_q, state_d;

  logic        hold_full_p0;
  logic        hold_sop_p0;
  logic [7:0]  hold_byte_p0;
  logic [7:0]  crc_p0;
  logic [15:0] cnt_p0;

  logic        acc_start, acc_mid, acc_eop, acc_abort;
  logic        load, emit, emit_last;
  logic [7:0]  crc_seed, crc_nxt;
  logic        fcs_match, len_ok, frame_good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Byte classification and next state; sop in BODY wins over eop (abort).
  always_comb begin
    state_d   = state_q;
    acc_start = 1'b0;
    acc_mid   = 1'b0;
    acc_eop   = 1'b0;
    acc_abort = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_vld && din_sop && !din_eop) begin
          acc_start = 1'b1;
          state_d   = BODY;
        end
      end
      BODY: begin
        if (din_vld && din_sop) begin
          acc_abort = 1'b1;
          if (din_eop) state_d = IDLE;
        end else if (din_vld && din_eop) begin
          acc_eop = 1'b1;
          state_d = IDLE;
        end else if (din_vld) begin
          acc_mid = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load      = acc_start | acc_mid | (acc_abort & ~din_eop);
  assign emit_last = acc_eop | acc_abort;
  assign emit      = hold_full_p0 & (acc_mid | emit_last);

  assign crc_seed = din_sop ? CRC_INIT : crc_p0;

  crc8_upd u_crc8_upd (
    .crc_in  (crc_seed),
    .byte_in (din),
    .crc_out (crc_nxt)
  );

  assign fcs_match  = (din == crc_p0);
  assign len_ok     = ({1'b0, cnt_p0} <= LEN_LIM);
  assign frame_good = fcs_match & len_ok;

  // Stage p0: hold register, running CRC and payload length of the open frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_p0 <= 1'b0;
      hold_sop_p0  <= 1'b0;
      crc_p0       <= CRC_INIT;
      cnt_p0       <= 16'd0;
    end else begin
      if (load) begin
        hold_full_p0 <= 1'b1;
        hold_sop_p0  <= din_sop;
        crc_p0       <= crc_nxt;
        cnt_p0       <= din_sop ? 16'd1 : sat_inc16(cnt_p0);
      end else if (emit_last) begin
        hold_full_p0 <= 1'b0;
        hold_sop_p0  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) hold_byte_p0 <= din;
  end

  // Stage p1: registered payload and verdict outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= 8'd0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_vld <= 1'b0;
      frm_ok   <= 1'b0;
      frm_err  <= 1'b0;
      frm_len  <= 16'd0;
    end else begin
      dout_vld <= emit;
      dout_sop <= emit & hold_sop_p0;
      dout_eop <= emit & emit_last;
      frm_ok   <= emit & acc_eop & frame_good;
      frm_err  <= emit & (acc_abort | (acc_eop & ~frame_good));
      if (emit) dout <= hold_byte_p0;
      if (emit && emit_last) frm_len <= cnt_p0;
    end
  end

`ifdef FRM_FCS_STAT_EN
  logic [15:0] good_q, bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_q <= 16'd0;
      bad_q  <= 16'd0;
    end else begin
      if (frm_ok)  good_q <= good_q + 16'd1;
      if (frm_err) bad_q  <= bad_q + 16'd1;
    end
  end

  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;
`else
  assign good_cnt = 16'd0;
  assign bad_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_frm_fcs_chk.sv
// Bench for frm_fcs_chk: directed frames followed by random frames, checked
// against a frame-level reference model of the expected payload and verdicts.
module tb_frm_fcs_chk;

  localparam int MAX_LEN_TB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_sop, din_eop, din_vld;
  logic [7:0]  dout;
  logic        dout_sop, dout_eop, dout_vld;
  logic        frm_ok, frm_err;
  logic [15:0] frm_len, good_cnt, bad_cnt;

  frm_fcs_chk #(.MAX_LEN(MAX_LEN_TB), .CRC_INIT(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop),
    .dout_vld (dout_vld),
    .frm_ok   (frm_ok),
    .frm_err  (frm_err),
    .frm_len  (frm_len),
    .good_cnt (good_cnt),
    .bad_cnt  (bad_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    logic        ok;
    logic        err;
    logic [15:0] len;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  pay[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_good = 0;
  int          exp_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC-8 over the whole payload, x^8+x^2+x+1, seed 0.
  function automatic logic [7:0] crc_ref();
    logic [7:0] c = 8'h00;
    logic       fb;
    foreach (pay[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ pay[i][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic s, input logic e,
                          input logic ok, input logic er, input int len);
    exp_t x;
    x.d = d; x.sop = s; x.eop = e; x.ok = ok; x.err = er; x.len = 16'(len);
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s, input logic e);
    din = b; din_sop = s; din_eop = e; din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fcs, input int gmin, input int gmax);
    int   n = pay.size();
    logic ok = (fcs == crc_ref()) && (n <= MAX_LEN_TB);
    for (int i = 0; i < n; i++)
      push_exp(pay[i], i == 0, i == n - 1, (i == n - 1) && ok, (i == n - 1) && !ok, n);
    for (int i = 0; i < n; i++) begin
      send_byte(pay[i], i == 0, 1'b0);
      idle($urandom_range(gmax, gmin));
    end
    send_byte(fcs, 1'b0, 1'b1);
  endtask

  task automatic send_abort(input int gmin, input int gmax);
    int n = pay.size();
    for (int i = 0; i < n; i++)
      push_exp(pay[i], i == 0, i == n - 1, 1'b0, i == n - 1, n);
    for (int i = 0; i < n; i++) begin
      send_byte(pay[i], i == 0, 1'b0);
      idle($urandom_range(gmax, gmin));
    end
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic chk_stats();
`ifdef FRM_FCS_STAT_EN
    chk("good_cnt", 32'(good_cnt), 32'(exp_good));
    chk("bad_cnt", 32'(bad_cnt), 32'(exp_bad));
`else
    chk("good_cnt_tied", 32'(good_cnt), 32'(exp_good * 0));
    chk("bad_cnt_tied", 32'(bad_cnt), 32'(exp_bad * 0));
`endif
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outs", {19'd0, dout, dout_sop, dout_eop, dout_vld, frm_ok, frm_err}, 32'd0);
      chk("rst_len", 32'(frm_len), 32'd0);
      chk("rst_cnts", {good_cnt, bad_cnt}, 32'd0);
    end else if (dout_vld) begin
      if (exp_q.size() == 0) begin
        chk("stray_vld", 32'(dout_vld), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dout", 32'(dout), 32'(mon_e.d));
        chk("dout_sop", 32'(dout_sop), 32'(mon_e.sop));
        chk("dout_eop", 32'(dout_eop), 32'(mon_e.eop));
        chk("frm_ok", 32'(frm_ok), 32'(mon_e.ok));
        chk("frm_err", 32'(frm_err), 32'(mon_e.err));
        if (mon_e.eop) begin
          chk("frm_len", 32'(frm_len), 32'(mon_e.len));
          if (mon_e.ok) exp_good++;
          else          exp_bad++;
        end
      end
    end else begin
      chk("quiet_flags", {28'd0, dout_sop, dout_eop, frm_ok, frm_err}, 32'd0);
    end
  end

  initial begin
    int kind;
    logic [7:0] fcs;
    rst_n = 1'b0; din = 8'h00; din_sop = 1'b0; din_eop = 1'b0; din_vld = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    pay = '{8'h01};
    send_frame(8'h07, 0, 0);
    idle(2);
    pay = '{8'h01, 8'h02};
    send_frame(8'h1B, 3, 3);
    idle(2);
    pay = '{8'h01};
    send_frame(8'h00, 0, 0);
    idle(2);

    pay = '{8'hAA, 8'hBB};
    send_abort(0, 0);
    pay = '{8'h01};
    send_frame(8'h07, 0, 0);
    idle(2);

    pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    send_frame(crc_ref(), 0, 1);
    idle(2);
    pay = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(crc_ref(), 0, 1);
    idle(2);

    send_byte(8'h5A, 1'b1, 1'b1);
    idle(2);
    send_byte(8'h66, 1'b0, 1'b0);
    send_byte(8'h77, 1'b0, 1'b1);
    idle(3);
    chk_stats();

    push_exp(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    push_exp(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    idle(2);
    rst_n = 1'b0;
    exp_good = 0;
    exp_bad = 0;
    idle(2);
    rst_n = 1'b1;
    send_byte(8'h44, 1'b0, 1'b1);
    idle(1);
    pay = '{8'h01, 8'h02};
    send_frame(8'h1B, 0, 0);
    idle(3);
    chk_stats();

    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(9, 0);
      rand_pay($urandom_range(7, 1));
      if (kind <= 4) begin
        send_frame(crc_ref(), 0, 2);
      end else if (kind <= 6) begin
        fcs = crc_ref() ^ 8'($urandom_range(255, 1));
        send_frame(fcs, 0, 2);
      end else if (kind == 7) begin
        send_abort(0, 2);
        rand_pay($urandom_range(5, 1));
        send_frame(crc_ref(), 0, 2);
      end else if (kind == 8) begin
        send_byte(8'($urandom_range(255, 0)), 1'b1, 1'b1);
      end else begin
        send_byte(8'($urandom_range(255, 0)), 1'b0, 1'($urandom_range(1, 0)));
      end
      idle($urandom_range(2, 0));
    end

    idle(5);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
